// File: rtl/i2c_master_controller.sv
// i2c_master_controller: single-byte I2C master (write or read) to a 7-bit
// addressed slave on open-drain SDA/SCL. Every bit is four quarter periods of
// DIV_Q clocks: SCL low in Q0-Q1, released in Q2-Q3. SDA changes at Q0 and is
// sampled at the start of Q3.
//
// Request handshake: ready is high only in IDLE. A request is taken on any
// rising clk edge where ready=1 and enable=1; addr/rw/data_in are captured on
// that edge. enable while ready=0 is ignored. done pulses for one clk when
// the STOP condition completes, in the same cycle ready returns high.
module i2c_master_controller #(
    parameter int DIV_Q = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       done,
    output logic       ack_err,
    inout  wire        sda,
    inout  wire        scl,
    output logic [3:0] dbg_state
);

    localparam int CW = (DIV_Q > 1) ? $clog2(DIV_Q) : 1;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        ADDR     = 4'd2,
        ADDR_ACK = 4'd3,
        WDATA    = 4'd4,
        WACK     = 4'd5,
        RDATA    = 4'd6,
        MNACK    = 4'd7,
        STOP     = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;       // clk count inside one quarter
    logic [1:0]      q_q;         // quarter index Q0..Q3
    logic [2:0]      bit_q;       // bit index inside a byte
    logic [7:0]      tx_q;        // outgoing byte, MSB presented on SDA
    logic [7:0]      wdata_q;     // write byte held until the address is ACKed
    logic [7:0]      rx_q;        // SDA samples; bit 0 is the latest one
    logic            rw_q;
    logic            done_q;
    logic            ack_err_q;
    logic [7:0]      data_out_q;
    logic            sda_low;
    logic            scl_low;

    logic tick, bit_end, byte_end;
    assign tick     = (cnt_q == CW'(DIV_Q - 1));
    assign bit_end  = tick && (q_q == 2'd3);
    assign byte_end = bit_end && (bit_q == 3'd7);

    // Lines are only ever pulled low or released; pull-ups provide the 1.
    assign sda = sda_low ? 1'b0 : 1'bz;
    assign scl = scl_low ? 1'b0 : 1'bz;

    assign ready     = (state_q == IDLE);
    assign done      = done_q;
    assign ack_err   = ack_err_q;
    assign data_out  = data_out_q;
    assign dbg_state = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state selection and open-drain line control for the current quarter.
    always_comb begin
        state_d = state_q;
        sda_low = 1'b0;
        scl_low = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = START;
            end
            START: begin
                sda_low = q_q[1];
                if (bit_end) state_d = ADDR;
            end
            ADDR: begin
                scl_low = !q_q[1];
                sda_low = !tx_q[7];
                if (byte_end) state_d = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_low = !q_q[1];
                if (bit_end) state_d = rx_q[0] ? STOP : (rw_q ? RDATA : WDATA);
            end
            WDATA: begin
                scl_low = !q_q[1];
                sda_low = !tx_q[7];
                if (byte_end) state_d = WACK;
            end
            WACK: begin
                scl_low = !q_q[1];
                if (bit_end) state_d = STOP;
            end
            RDATA: begin
                scl_low = !q_q[1];
                if (byte_end) state_d = MNACK;
            end
            MNACK: begin
                scl_low = !q_q[1];
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                scl_low = !q_q[1];
                sda_low = (q_q != 2'd3);
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Quarter/bit timing, byte shifting, request capture and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            q_q        <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            wdata_q    <= '0;
            rx_q       <= '0;
            rw_q       <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            data_out_q <= '0;
        end else begin
            done_q <= (state_q == STOP) && bit_end;
            if (state_q == IDLE) begin
                cnt_q <= '0;
                q_q   <= '0;
                bit_q <= '0;
                if (enable) begin
                    tx_q      <= {addr, rw};
                    rw_q      <= rw;
                    wdata_q   <= data_in;
                    ack_err_q <= 1'b0;
                end
            end else begin
                cnt_q <= tick ? '0 : cnt_q + CW'(1);
                if (tick) q_q <= q_q + 2'd1;
                // Start of Q3: SCL has been released for a full quarter.
                if (tick && (q_q == 2'd2)) rx_q <= {rx_q[6:0], sda};
                if (bit_end) begin
                    case (state_q)
                        ADDR, WDATA: begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= {tx_q[6:0], 1'b0};
                        end
                        RDATA: begin
                            bit_q <= bit_q + 3'd1;
                            if (bit_q == 3'd7) data_out_q <= rx_q;
                        end
                        ADDR_ACK: begin
                            if (rx_q[0]) ack_err_q <= 1'b1;
                            else         tx_q      <= wdata_q;
                        end
                        WACK: begin
                            if (rx_q[0]) ack_err_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: a bus-level slave model decodes START/STOP
// and bytes from sda/scl, answers ACK/NACK and read data; a reference model
// predicts each transaction's outcome and queues it for the done monitor.
module tb_i2c_master_controller;

  localparam int DIV_Q = 4;
  localparam logic [6:0] SLV = 7'h56;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic       enable = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       ready, done, ack_err;
  logic [3:0] dbg_state;
  wire        sda, scl;

  pullup (sda);
  pullup (scl);

  i2c_master_controller #(.DIV_Q(DIV_Q)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ready(ready), .done(done),
    .ack_err(ack_err), .sda(sda), .scl(scl), .dbg_state(dbg_state)
  );

  // ---------------- counters / check ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- slave model on the bus ----------------
  logic       slv_low = 1'b0;
  logic [7:0] slv_rd = '0;
  logic       slv_wnack = 1'b0;
  logic       b_act = 1'b0, b_rd = 1'b0, b_acked = 1'b0, b_stop = 1'b0, b_mack = 1'b0;
  logic [7:0] b_sh = '0, b_addr = '0, b_wbyte = '0, b_rbyte = '0;
  int         b_nb = 0, b_nbytes = 0, od_viol = 0;

  assign sda = slv_low ? 1'b0 : 1'bz;

  initial begin : slave_model
    logic s, c, p_sda, p_scl;
    int pos, bidx;
    p_sda = 1'b1;
    p_scl = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slv_low = 1'b0;
        b_act = 1'b0;
        p_sda = 1'b1;
        p_scl = 1'b1;
      end else begin
        s = sda;
        c = scl;
        if (slv_low && (s !== 1'b0)) od_viol++;
        if ((^{sda, scl}) === 1'bx) od_viol++;
        if (p_scl && c && p_sda && !s) begin
          b_act = 1'b1; b_nb = 0; b_nbytes = 0; b_stop = 1'b0; slv_low = 1'b0; b_mack = 1'b0;
        end else if (p_scl && c && !p_sda && s) begin
          b_stop = 1'b1; b_act = 1'b0; slv_low = 1'b0;
        end else if (b_act && !p_scl && c) begin
          pos = b_nb % 9;
          bidx = b_nb / 9;
          if (pos < 8) b_sh = {b_sh[6:0], s};
          else if (bidx > 0 && b_rd) b_mack = s;
          if (pos == 7) begin
            if (bidx == 0) begin
              b_addr = b_sh; b_rd = b_sh[0]; b_acked = (b_sh[7:1] == SLV);
            end else begin
              b_nbytes++;
              if (b_rd) b_rbyte = b_sh; else b_wbyte = b_sh;
            end
          end
          b_nb++;
        end else if (b_act && p_scl && !c) begin
          pos = b_nb % 9;
          bidx = b_nb / 9;
          slv_low = 1'b0;
          if (pos == 8) begin
            if (bidx == 0) slv_low = b_acked;
            else if (!b_rd) slv_low = b_acked && !slv_wnack;
          end else if (bidx == 1 && b_rd && b_acked) begin
            slv_low = !slv_rd[7-pos];
          end
        end
        p_sda = s;
        p_scl = c;
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [7:0] addr_byte;
    logic       acked;
    logic       rw;
    logic [7:0] wbyte;
    logic [7:0] rbyte;
    logic       ack_err;
    logic [7:0] dout;
    int         done_cyc;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] model_dout = '0;
  int n_issued = 0, n_done = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no transaction (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("ack_err", ack_err, e.ack_err);
          check("data_out", data_out, e.dout);
          check("ready_at_done", ready, 1);
          check("bus_addr_byte", b_addr, e.addr_byte);
          check("bus_stop", b_stop, 1);
          check("bus_data_bytes", b_nbytes, e.acked ? 1 : 0);
          if (e.acked && !e.rw) check("bus_write_byte", b_wbyte, e.wbyte);
          if (e.acked && e.rw) begin
            check("bus_read_byte", b_rbyte, e.rbyte);
            check("master_nack", b_mack, 1);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle (or at the done cycle).
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                         input logic [7:0] rd, input logic wn, input logic b2b);
    exp_t e;
    bit got;
    addr = a; rw = r; data_in = d; enable = 1'b1;
    slv_rd = rd; slv_wnack = wn;
    e.acked = (a == SLV);
    e.rw = r;
    e.addr_byte = {a, r};
    e.wbyte = d;
    e.rbyte = rd;
    e.ack_err = !e.acked || (!r && wn);
    if (e.acked && r) model_dout = rd;
    e.dout = model_dout;
    e.done_cyc = cyc + (e.acked ? 80 : 44) * DIV_Q + 1;
    exp_q.push_back(e);
    n_issued++;
    @(negedge clk);
    // Busy period: scramble the request inputs; none of it may start anything.
    for (int k = 0; k < 100; k++) begin
      addr = 7'($urandom);
      rw = 1'($urandom);
      data_in = 8'($urandom);
      enable = b2b ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (!b2b) enable = 1'b0;
    got = 0;
    for (int k = 0; k < 1000; k++) begin
      if (done) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done expected done by cycle %0d", e.done_cyc);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got no end of test expected finish (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [6:0] ra;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_data_out", data_out, 0);
    check("rst_sda", sda, 1);
    check("rst_scl", scl, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed write, read, address NACK
    run_txn(7'h56, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0);
    run_txn(7'h56, 1'b1, 8'h00, 8'hCC, 1'b0, 1'b0);
    run_txn(7'h12, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0);
    // write byte NACKed
    run_txn(7'h56, 1'b0, 8'h81, 8'h00, 1'b1, 1'b0);
    // back-to-back with enable held
    run_txn(7'h56, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b1);
    run_txn(7'h56, 1'b1, 8'h00, 8'h3E, 1'b0, 1'b1);
    run_txn(7'h12, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1);
    run_txn(7'h56, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);

    // randomized
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) ra = SLV;
      else begin
        do ra = 7'($urandom); while (ra == SLV);
      end
      run_txn(ra, 1'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    // reset in the middle of the write data byte (bit 3)
    enable = 1'b0;
    @(negedge clk);
    addr = SLV; rw = 1'b0; data_in = 8'h3C; slv_wnack = 1'b0; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (212) @(negedge clk);
    check("pre_reset_in_wdata", dbg_state, 4);
    rst_n = 1'b0;
    model_dout = '0;
    #1;
    check("mid_rst_sda", sda, 1);
    check("mid_rst_scl", scl, 1);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_data_out", data_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(7'h56, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0);
    run_txn(7'h56, 1'b1, 8'h00, 8'h96, 1'b0, 1'b0);

    enable = 1'b0;
    repeat (400) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);
    check("done_count", n_done, n_issued);
    check("open_drain_violations", od_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
